// File: rtl/fake_tdc_gen.sv
// Fake TDC event source: emits {ch_id, payload} words at a programmable interval with a FIFO handshake.
// Optional macro FAKE_TDC_LFSR_EN switches the payload from a sequence counter to a 16-bit LFSR.
module fake_tdc_gen #(
    parameter int          N_CH      = 4,
    parameter int          DATA_W    = 16,
    parameter int          CNT_W     = 30,
    parameter int          DROP_W    = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic [CNT_W-1:0]                      period,
    input  logic                                  fifo_full,
    input  logic                                  f_FIFO_writing_done,
    output logic                                  wr_en,
    output logic [DATA_W-1:0]                     data,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_id,
    output logic                                  busy,
    output logic [DROP_W-1:0]                     drop_cnt
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int SEQ_W = DATA_W - CH_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DELAY     = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t              state_r, state_next_s;
    logic [CNT_W-1:0]    cntr_r, cntr_next_s;
    logic [CNT_W-1:0]    per_r, per_next_s, per_in_s;
    logic [CH_W-1:0]     ch_id_r, ch_id_next_s;
    logic                wr_en_r, wr_en_next_s;
    logic [DATA_W-1:0]   data_r, data_next_s;
    logic                busy_r, busy_next_s;
    logic [DROP_W-1:0]   drop_cnt_r, drop_cnt_next_s;
    logic [SEQ_W-1:0]    payload_s;
    logic                advance_s;
    logic                write_s;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        if (ch == CH_LAST) begin
            return {CH_W{1'b0}};
        end else begin
            return ch + {{(CH_W-1){1'b0}}, 1'b1};
        end
    endfunction

`ifdef FAKE_TDC_LFSR_EN
    logic [15:0] lfsr_r, lfsr_next_s;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Payload source and its advance
    always_comb begin
        payload_s   = SEQ_W'(lfsr_r);
        lfsr_next_s = lfsr_r;
        if (advance_s) begin
            lfsr_next_s = lfsr_step(lfsr_r);
        end else begin
            lfsr_next_s = lfsr_r;
        end
    end
`else
    logic [SEQ_W-1:0] seq_r, seq_next_s;

    // Payload source and its advance
    always_comb begin
        payload_s  = seq_r;
        seq_next_s = seq_r;
        if (advance_s) begin
            seq_next_s = seq_r + {{(SEQ_W-1){1'b0}}, 1'b1};
        end else begin
            seq_next_s = seq_r;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; an accepted write always completes regardless of enable
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:      state_next_s = enable ? DELAY : IDLE;
            DELAY: begin
                if (!enable) begin
                    state_next_s = IDLE;
                end else if (cntr_r == per_r - CNT_ONE) begin
                    state_next_s = SEND;
                end else begin
                    state_next_s = DELAY;
                end
            end
            SEND:      state_next_s = fifo_full ? DELAY : WAIT_DONE;
            WAIT_DONE: begin
                if (f_FIFO_writing_done) begin
                    state_next_s = enable ? DELAY : IDLE;
                end else begin
                    state_next_s = WAIT_DONE;
                end
            end
            default:   state_next_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        per_in_s  = (period == {CNT_W{1'b0}}) ? CNT_ONE : period;
        write_s   = (state_r == SEND) && !fifo_full;
        advance_s = ((state_r == SEND) && fifo_full) ||
                    ((state_r == WAIT_DONE) && f_FIFO_writing_done);

        if ((state_next_s == DELAY) && (state_r == DELAY)) begin
            cntr_next_s = cntr_r + CNT_ONE;
        end else begin
            cntr_next_s = {CNT_W{1'b0}};
        end

        if ((state_next_s == DELAY) && (state_r != DELAY)) begin
            per_next_s = per_in_s;
        end else begin
            per_next_s = per_r;
        end

        wr_en_next_s = (state_next_s == WAIT_DONE);
        busy_next_s  = (state_next_s != IDLE);
        data_next_s  = write_s ? {ch_id_r, payload_s} : data_r;
        ch_id_next_s = advance_s ? next_ch(ch_id_r) : ch_id_r;

        if ((state_r == SEND) && fifo_full && (drop_cnt_r != {DROP_W{1'b1}})) begin
            drop_cnt_next_s = drop_cnt_r + {{(DROP_W-1){1'b0}}, 1'b1};
        end else begin
            drop_cnt_next_s = drop_cnt_r;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntr_r     <= {CNT_W{1'b0}};
            per_r      <= CNT_ONE;
            ch_id_r    <= {CH_W{1'b0}};
            wr_en_r    <= 1'b0;
            data_r     <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
            drop_cnt_r <= {DROP_W{1'b0}};
`ifdef FAKE_TDC_LFSR_EN
            lfsr_r     <= LFSR_SEED;
`else
            seq_r      <= {SEQ_W{1'b0}};
`endif
        end else begin
            cntr_r     <= cntr_next_s;
            per_r      <= per_next_s;
            ch_id_r    <= ch_id_next_s;
            wr_en_r    <= wr_en_next_s;
            data_r     <= data_next_s;
            busy_r     <= busy_next_s;
            drop_cnt_r <= drop_cnt_next_s;
`ifdef FAKE_TDC_LFSR_EN
            lfsr_r     <= lfsr_next_s;
`else
            seq_r      <= seq_next_s;
`endif
        end
    end

    assign wr_en    = wr_en_r;
    assign data     = data_r;
    assign ch_id    = ch_id_r;
    assign busy     = busy_r;
    assign drop_cnt = drop_cnt_r;

endmodule
